// File: rtl/sensor_frontend.sv
// sensor_frontend: synchronizes and debounces three bouncy sensor pins and queues their rising edges as events.
// Ports:
//   clk, reset (async, active-low)
//   raw_sensor1..3  : asynchronous bouncy inputs
//   sensor1..3      : debounced levels
//   event_valid/id  : lowest-numbered pending rise (id 1..3, 0 when idle)
//   event_ready     : consumer handshake
//   event_count     : saturating count of accepted events
//   overrun         : sticky, a rise hit a channel whose event was still pending
module sensor_frontend #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       raw_sensor1,
    input  logic       raw_sensor2,
    input  logic       raw_sensor3,
    output logic       sensor1,
    output logic       sensor2,
    output logic       sensor3,
    output logic       event_valid,
    output logic [1:0] event_id,
    input  logic       event_ready,
    output logic [7:0] event_count,
    output logic       overrun
);
    logic [2:0] raw, s1_q, s2_q, sens_q, sens_d, flip, pend_q, pend_d, rise, clr;
    logic [3:0] cnt_q [3];
    logic [3:0] cnt_d [3];
    logic [7:0] count_q, count_d;
    logic       ovr_q, ovr_d, hs;

    assign raw = {raw_sensor3, raw_sensor2, raw_sensor1};

    // the counter tracks consecutive clocks the synchronized level has disagreed with the output
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            flip[i]   = (s2_q[i] != sens_q[i]) && (cnt_q[i] == 4'(DEBOUNCE_CYCLES - 1));
            sens_d[i] = flip[i] ? s2_q[i] : sens_q[i];
            cnt_d[i]  = (s2_q[i] == sens_q[i] || flip[i]) ? 4'd0 : cnt_q[i] + 4'd1;
        end
    end

    assign event_valid = |pend_q;
    assign event_id    = pend_q[0] ? 2'd1 : pend_q[1] ? 2'd2 : pend_q[2] ? 2'd3 : 2'd0;
    assign hs          = event_valid & event_ready;
    assign clr         = {hs & (event_id == 2'd3), hs & (event_id == 2'd2), hs & (event_id == 2'd1)};
    assign rise        = sens_d & ~sens_q;
    // a rise on the edge its own pending bit is being consumed re-arms it without overrun
    assign pend_d      = (pend_q & ~clr) | rise;
    assign ovr_d       = ovr_q | (|(rise & pend_q & ~clr));
    assign count_d     = (hs && count_q != 8'hFF) ? count_q + 8'd1 : count_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_q    <= '0;
            s2_q    <= '0;
            sens_q  <= '0;
            pend_q  <= '0;
            count_q <= '0;
            ovr_q   <= 1'b0;
            for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
        end else begin
            s1_q    <= raw;
            s2_q    <= s1_q;
            sens_q  <= sens_d;
            pend_q  <= pend_d;
            count_q <= count_d;
            ovr_q   <= ovr_d;
            for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign {sensor3, sensor2, sensor1} = sens_q;
    assign event_count                 = count_q;
    assign overrun                     = ovr_q;
endmodule

// File: tb/tb_sensor_frontend.sv
// tb_sensor_frontend: randomized scoreboard bench for sensor_frontend against a history-based reference model.
module tb_sensor_frontend;
    localparam int D = 4;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [2:0] raw = '0;
    logic       event_ready = 1'b0;
    logic       sensor1, sensor2, sensor3, event_valid, overrun;
    logic [1:0] event_id;
    logic [7:0] event_count;

    int checks = 0;
    int errors = 0;

    bit m_sens [3];
    bit m_pend [3];
    int m_cnt = 0;
    bit m_ovr = 1'b0;
    bit raw_hist [3][$];
    bit din_hist [3][$];
    int exp_q [$];

    sensor_frontend #(.DEBOUNCE_CYCLES(D)) dut (
        .clk(clk), .reset(reset),
        .raw_sensor1(raw[0]), .raw_sensor2(raw[1]), .raw_sensor3(raw[2]),
        .sensor1(sensor1), .sensor2(sensor2), .sensor3(sensor3),
        .event_valid(event_valid), .event_id(event_id), .event_ready(event_ready),
        .event_count(event_count), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic int m_id();
        for (int i = 0; i < 3; i++) if (m_pend[i]) return i + 1;
        return 0;
    endfunction

    task automatic m_reset();
        m_cnt = 0;
        m_ovr = 0;
        exp_q.delete();
        for (int i = 0; i < 3; i++) begin
            m_sens[i] = 0;
            m_pend[i] = 0;
            raw_hist[i].delete();
            din_hist[i].delete();
        end
    endtask

    // Monitor + model: outputs are compared mid-cycle, then the model advances over the next rising edge.
    initial begin
        m_reset();
        forever begin
            @(negedge clk);
            if (!reset) m_reset();
            chk("sensor1", int'(sensor1), int'(m_sens[0]));
            chk("sensor2", int'(sensor2), int'(m_sens[1]));
            chk("sensor3", int'(sensor3), int'(m_sens[2]));
            chk("event_valid", int'(event_valid), int'(m_id() != 0));
            chk("event_id", int'(event_id), m_id());
            chk("event_count", int'(event_count), m_cnt);
            chk("overrun", int'(overrun), int'(m_ovr));
            if (reset) begin
                bit hs;
                int hid;
                hid = m_id();
                hs  = (hid != 0) && event_ready;
                if (hs) begin
                    exp_q.push_back(hid);
                    m_cnt = (m_cnt == 255) ? 255 : m_cnt + 1;
                end
                if (event_valid && event_ready) begin
                    if (exp_q.size() == 0) chk("sb_unexpected_handshake", int'(event_id), 0);
                    else chk("sb_event_id", int'(event_id), exp_q.pop_front());
                end
                for (int i = 0; i < 3; i++) begin
                    bit din, all_diff, rise, cleared;
                    int n;
                    raw_hist[i].push_back(raw[i]);
                    n   = raw_hist[i].size();
                    // the debouncer sees the raw level from two edges earlier
                    din = (n >= 3) ? raw_hist[i][n-3] : 1'b0;
                    din_hist[i].push_back(din);
                    n = din_hist[i].size();
                    all_diff = (n >= D);
                    for (int k = 0; k < D && k < n; k++)
                        if (din_hist[i][n-1-k] == m_sens[i]) all_diff = 0;
                    rise = all_diff && !m_sens[i];
                    if (all_diff) m_sens[i] = !m_sens[i];
                    cleared = hs && (hid == i + 1);
                    if (rise && m_pend[i] && !cleared) m_ovr = 1;
                    if (cleared) m_pend[i] = 0;
                    if (rise) m_pend[i] = 1;
                    if (raw_hist[i].size() > 8) void'(raw_hist[i].pop_front());
                    if (din_hist[i].size() > D + 4) void'(din_hist[i].pop_front());
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int n;
        cyc(3);
        reset = 1'b1;
        cyc(2);
        // single rise on channel 1, held while consumer stalls, then one handshake
        raw[0] = 1'b1;
        cyc(10);
        chk("ch1_pending_id", int'(event_id), 1);
        event_ready = 1'b1;
        cyc(1);
        event_ready = 1'b0;
        chk("ch1_count", int'(event_count), 1);
        chk("ch1_valid_cleared", int'(event_valid), 0);
        raw[0] = 1'b0;
        cyc(10);
        // short pulse rejected, long pulse accepted
        raw[1] = 1'b1; cyc(3); raw[1] = 1'b0;
        cyc(10);
        chk("short_pulse_sensor2", int'(sensor2), 0);
        raw[1] = 1'b1; cyc(5); raw[1] = 1'b0;
        cyc(10);
        chk("long_pulse_event", int'(event_id), 2);
        // simultaneous rises on 2 and 3 with consumer always ready
        event_ready = 1'b1;
        cyc(3);
        raw[2:1] = 2'b11;
        cyc(12);
        chk("dual_rise_count", int'(event_count), 4);
        raw[2:1] = 2'b00;
        cyc(10);
        // overrun: second rise on channel 3 while its first event is unconsumed
        event_ready = 1'b0;
        raw[2] = 1'b1; cyc(10);
        raw[2] = 1'b0; cyc(10);
        chk("overrun_before", int'(overrun), 0);
        raw[2] = 1'b1; cyc(10);
        chk("overrun_set", int'(overrun), 1);
        event_ready = 1'b1;
        cyc(10);
        chk("overrun_sticky", int'(overrun), 1);
        // random bouncy traffic with random back-pressure
        for (int t = 0; t < 2000; t++) begin
            for (int i = 0; i < 3; i++) if ($urandom_range(7) == 0) raw[i] = ~raw[i];
            event_ready = 1'($urandom_range(1));
            cyc(1);
        end
        // drive well over 255 accepted events
        event_ready = 1'b1;
        raw = '0;
        cyc(10);
        for (int t = 0; t < 110; t++) begin
            raw = 3'b111; cyc(6);
            raw = 3'b000; cyc(6);
        end
        cyc(5);
        chk("count_saturated", int'(event_count), 255);
        // asynchronous reset in the middle of a channel-1 debounce
        raw[0] = 1'b1;
        cyc(3);
        reset = 1'b0;
        #1;
        chk("rst_sensors", int'({sensor3, sensor2, sensor1}), 0);
        chk("rst_valid", int'(event_valid), 0);
        chk("rst_id", int'(event_id), 0);
        chk("rst_count", int'(event_count), 0);
        chk("rst_overrun", int'(overrun), 0);
        cyc(2);
        reset = 1'b1;
        n = 0;
        while (n < 20) begin
            @(posedge clk);
            n++;
            #1;
            if (sensor1) break;
        end
        chk("post_reset_latency", n, 2 + D);
        cyc(5);
        chk("sb_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sensor_frontend.md
SENSOR_FRONTEND -- requirements
Module: sensor_frontend

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 4, meaning consecutive stable clocks required to accept a level change (legal range 2..15).
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state on rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit; reset is asynchronous and active-low.
REQ-004 The block SHALL have ports raw_sensor1/raw_sensor2/raw_sensor3, input, 1 bit each: asynchronous, bouncy sensor pins.
REQ-005 The block SHALL have ports sensor1/sensor2/sensor3, output, 1 bit each: debounced levels for the buzzer state machine.
REQ-006 The block SHALL have port event_valid, output, 1 bit: at least one rising-edge event pending.
REQ-007 The block SHALL have port event_id, output, 2 bits: pending channel (1,2,3), 0 when none.
REQ-008 The block SHALL have port event_ready, input, 1 bit: consumer accepts the presented event.
REQ-009 The block SHALL have port event_count, output, 8 bits: accepted events, saturating.
REQ-010 The block SHALL have port overrun, output, 1 bit: sticky flag, new rise on an already-pending channel.

Function
REQ-011 Each raw input SHALL pass through a two-flop synchronizer (s1, s2) before any other use.
REQ-012 Each channel SHALL hold a 4-bit stability counter: cleared when s2 equals the channel output; incremented when s2 differs.
REQ-013 When s2 differs from the output and the counter equals DEBOUNCE_CYCLES-1, the output SHALL take s2 on that edge and the counter SHALL clear.
REQ-014 A clean raw change SHALL appear on sensorN at the (2+DEBOUNCE_CYCLES)th rising edge after it (6 with default).
REQ-015 An s2 pulse shorter than DEBOUNCE_CYCLES clocks SHALL not change sensorN; falling edges SHALL debounce identically.
REQ-016 On the edge where sensorN goes 0->1, pending[N] SHALL set; falling edges SHALL create no event.
REQ-017 event_valid SHALL be combinational OR of pending[3:1]; event_id SHALL be the lowest-numbered pending channel (1 > 2 > 3).
REQ-018 A handshake SHALL occur on an edge with event_valid=1 and event_ready=1; it SHALL clear pending[event_id] and increment event_count.
REQ-019 event_count SHALL saturate at 255; further handshakes leave it at 255.
REQ-020 If a rise sets pending[N] on the same edge a handshake clears pending[N], set SHALL win, count still increments, overrun SHALL not set.
REQ-021 If a rise occurs while pending[N] is already set and not being cleared on that edge, overrun SHALL set and remain 1 until reset.
REQ-022 event_id/event_valid SHALL be held stable while event_valid=1 and event_ready=0, except that a higher-priority new event MAY replace event_id.
REQ-023 event_ready while event_valid=0 SHALL have no effect.
REQ-024 Channels SHALL be independent; simultaneous rises on several channels SHALL set all corresponding pending bits on one edge.

Reset
REQ-025 reset low SHALL immediately clear synchronizers, counters, sensor1..3, pending, event_count and overrun to 0, regardless of clk.
REQ-026 Assertion mid-debounce or mid-handshake SHALL discard all in-progress state; after release raw inputs already high SHALL be re-qualified from scratch (full 2+DEBOUNCE_CYCLES latency).
REQ-027 reset release SHALL be synchronized by the integrator; the block needs no behaviour beyond REQ-025 at release.

Verification
REQ-028 Reset low, all raw=0 -> sensor1..3=0, event_valid=0, event_id=0, event_count=0, overrun=0.
REQ-029 raw_sensor1 0->1 held, event_ready=0 -> sensor1=1 at 6th edge, event_valid=1, event_id=1; ready=1 one clock -> event_valid=0, event_count=1.
REQ-030 raw_sensor2 pulses high 3 clocks (shorter than debounce) -> sensor2 stays 0, no event; 4+ clocks -> sensor2 rises.
REQ-031 raw_sensor2 and raw_sensor3 rise same cycle, ready=1 always -> event_id=2 then 3 on consecutive cycles, event_count+2.
REQ-032 sensor3 event pending, ready=0, sensor3 debounced fall then rise -> overrun=1, stays 1; only reset clears it.
REQ-033 300 accepted events -> event_count=255; reset asserted mid-debounce of raw_sensor1 -> all outputs 0 at once, 6-edge latency restarts after release.
